// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds FSM states, data-width encodings and oversampling sample points.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_MAX   = 8;

    // Start bit is checked half a bit in; later bits one full bit apart.
    localparam logic [3:0] START_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] BIT_SAMPLE   = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    typedef enum logic [1:0] {
        DW5 = 2'b00,
        DW6 = 2'b01,
        DW7 = 2'b10,
        DW8 = 2'b11
    } data_width_t;

    // Index of the last data bit: 5 bits -> 4 ... 8 bits -> 7.
    function automatic logic [2:0] last_bit(input data_width_t w);
        return {1'b1, w};
    endfunction

    // Right shift that aligns an LSB-first shift register: 8 - bits.
    function automatic logic [1:0] align_shift(input data_width_t w);
        return ~w;
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// UART receive engine: 16x oversampled start/data/parity/stop sampling.
// Ports: clk_i, rst_n_i, rx_i, sample_tick_i, enable_i, frame config in;
//        data_o, data_valid_o, parity_error_o, frame_error_o out.
module uart_receiver
    import uart_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rx_i,
    input  logic                sample_tick_i,
    input  logic                enable_i,
    input  logic [1:0]          data_width_i,
    input  logic                parity_en_i,
    input  logic                parity_odd_i,
    input  logic                stop_bits_i,
    output logic [DATA_MAX-1:0] data_o,
    output logic                data_valid_o,
    output logic                parity_error_o,
    output logic                frame_error_o
);

    rx_state_t   r_state;
    rx_state_t   w_state_n;
    logic [3:0]  r_tick_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    data_width_t r_width;
    logic        r_par_en;
    logic        r_par_odd;
    logic        r_two_stop;
    logic        r_stop2;
    logic        r_par_err;
    logic        r_frm_err;

    logic        w_mid;
    logic        w_bit_pt;
    logic        w_last_data;
    logic [7:0]  w_data;

    assign w_mid       = sample_tick_i && (r_tick_cnt == START_SAMPLE);
    assign w_bit_pt    = sample_tick_i && (r_tick_cnt == BIT_SAMPLE);
    assign w_last_data = (r_bit_cnt == last_bit(r_width));
    // Bits enter at the MSB, so a short character sits in the top bits.
    assign w_data      = r_shift >> align_shift(r_width);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (sample_tick_i && !rx_i) w_state_n = START;
            end
            START: begin
                if (w_mid) w_state_n = rx_i ? IDLE : DATA;
            end
            DATA: begin
                if (w_bit_pt && w_last_data)
                    w_state_n = r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bit_pt) w_state_n = STOP;
            end
            STOP: begin
                if (w_bit_pt && (!r_two_stop || r_stop2))
                    w_state_n = DONE;
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        // Disable aborts any frame; IDLE clears the frame context.
        if (!enable_i) w_state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tick_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_width        <= DW8;
            r_par_en       <= 1'b0;
            r_par_odd      <= 1'b0;
            r_two_stop     <= 1'b0;
            r_stop2        <= 1'b0;
            r_par_err      <= 1'b0;
            r_frm_err      <= 1'b0;
            data_o         <= '0;
            data_valid_o   <= 1'b0;
            parity_error_o <= 1'b0;
            frame_error_o  <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_shift    <= '0;
                    r_stop2    <= 1'b0;
                    r_par_err  <= 1'b0;
                    r_frm_err  <= 1'b0;
                end
                START: begin
                    if (sample_tick_i) begin
                        if (w_mid) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            if (!rx_i) begin
                                r_width    <= data_width_t'(data_width_i);
                                r_par_en   <= parity_en_i;
                                r_par_odd  <= parity_odd_i;
                                r_two_stop <= stop_bits_i;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick_i) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_bit_pt) begin
                            r_shift   <= {rx_i, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick_i) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        // Mismatch against even XOR, inverted for odd.
                        if (w_bit_pt)
                            r_par_err <= rx_i ^ (^w_data) ^ r_par_odd;
                    end
                end
                STOP: begin
                    if (sample_tick_i) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (w_bit_pt) begin
                            if (!rx_i) r_frm_err <= 1'b1;
                            r_stop2 <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (enable_i) begin
                        data_o         <= w_data;
                        parity_error_o <= r_par_err;
                        frame_error_o  <= r_frm_err;
                        data_valid_o   <= 1'b1;
                    end
                end
                default: begin
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver.
// Tick every 4 clks, so one bit period is 64 clks.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       tick = 1'b0;
    logic       en;
    logic [1:0] dw;
    logic       pen;
    logic       podd;
    logic       sb;
    logic [7:0] data;
    logic       dv;
    logic       perr;
    logic       ferr;

    int         tests = 0;
    int         fails = 0;
    int         vcount = 0;
    logic [7:0] cap_d = '0;
    logic       cap_p = 1'b0;
    logic       cap_f = 1'b0;
    logic       prev_dv = 1'b0;
    logic [1:0] tdiv = '0;

    uart_receiver dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .rx_i           (rx),
        .sample_tick_i  (tick),
        .enable_i       (en),
        .data_width_i   (dw),
        .parity_en_i    (pen),
        .parity_odd_i   (podd),
        .stop_bits_i    (sb),
        .data_o         (data),
        .data_valid_o   (dv),
        .parity_error_o (perr),
        .frame_error_o  (ferr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv = tdiv + 2'd1;
        tick = (tdiv == 2'd0);
    end

    always @(posedge clk) begin
        #1;
        if (dv) begin
            tests++;
            if (prev_dv) begin
                fails++;
                $display("FAIL valid_pulse: dv high 2 clks, want 1");
            end
            vcount++;
            cap_d = data;
            cap_p = perr;
            cap_f = ferr;
        end
        prev_dv = dv;
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic pe,
                           input logic po, input logic s);
        dw = w;
        pen = pe;
        podd = po;
        sb = s;
    endtask

    // Last stop bit is held only 40 clks: past its mid-bit sample.
    task automatic send_frame(input logic [7:0] d, input int nb,
                              input bit has_p, input bit p,
                              input bit two, input bit s1,
                              input bit s2);
        drive(1'b0, 64);
        for (int i = 0; i < nb; i++) drive(d[i], 64);
        if (has_p) drive(p, 64);
        if (two) begin
            drive(s1, 64);
            drive(s2, 40);
        end else begin
            drive(s1, 40);
        end
        drive(1'b1, 150);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx = 1'b1;
        en = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        tests += 4;
        if (data !== 8'h00) begin
            fails++; $display("FAIL rst_data: got %h want 00", data);
        end
        if (dv !== 1'b0) begin
            fails++; $display("FAIL rst_valid: got %b want 0", dv);
        end
        if (perr !== 1'b0) begin
            fails++; $display("FAIL rst_perr: got %b want 0", perr);
        end
        if (ferr !== 1'b0) begin
            fails++; $display("FAIL rst_ferr: got %b want 0", ferr);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1;
        int v0;
        v0 = vcount;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 0, 0, 0, 1, 1);
        tests += 4;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL 8n1_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'hA5) begin
            fails++; $display("FAIL 8n1_data: got %h want a5", cap_d);
        end
        if (cap_p !== 1'b0) begin
            fails++; $display("FAIL 8n1_perr: got %b want 0", cap_p);
        end
        if (cap_f !== 1'b0) begin
            fails++; $display("FAIL 8n1_ferr: got %b want 0", cap_f);
        end
    endtask

    task automatic test_7e1;
        int v0;
        v0 = vcount;
        set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1, 0, 0, 1, 1);
        tests += 3;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL 7e1_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h41) begin
            fails++; $display("FAIL 7e1_data: got %h want 41", cap_d);
        end
        if (cap_p !== 1'b0) begin
            fails++; $display("FAIL 7e1_perr: got %b want 0", cap_p);
        end
        v0 = vcount;
        send_frame(8'h41, 7, 1, 1, 0, 1, 1);
        tests += 4;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL 7e1b_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h41) begin
            fails++; $display("FAIL 7e1b_data: got %h want 41", cap_d);
        end
        if (cap_p !== 1'b1) begin
            fails++; $display("FAIL 7e1b_perr: got %b want 1", cap_p);
        end
        if (cap_f !== 1'b0) begin
            fails++; $display("FAIL 7e1b_ferr: got %b want 0", cap_f);
        end
    endtask

    task automatic test_8n2_frame_err;
        int v0;
        v0 = vcount;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 0);
        tests += 4;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL 8n2_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h3C) begin
            fails++; $display("FAIL 8n2_data: got %h want 3c", cap_d);
        end
        if (cap_f !== 1'b1) begin
            fails++; $display("FAIL 8n2_ferr: got %b want 1", cap_f);
        end
        if (cap_p !== 1'b0) begin
            fails++; $display("FAIL 8n2_perr: got %b want 0", cap_p);
        end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = vcount;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16);
        drive(1'b1, 150);
        tests += 2;
        if (vcount !== v0) begin
            fails++; $display("FAIL glitch_cnt: got %0d want %0d", vcount, v0);
        end
        if (ferr !== 1'b1) begin
            fails++; $display("FAIL glitch_ferr_hold: got %b want 1", ferr);
        end
        send_frame(8'h5A, 8, 0, 0, 0, 1, 1);
        tests += 3;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL post_glitch_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h5A) begin
            fails++; $display("FAIL post_glitch_data: got %h want 5a", cap_d);
        end
        if (cap_f !== 1'b0) begin
            fails++; $display("FAIL post_glitch_ferr: got %b want 0", cap_f);
        end
    endtask

    task automatic test_5o1;
        int v0;
        v0 = vcount;
        set_cfg(2'b00, 1'b1, 1'b1, 1'b0);
        send_frame(8'h1F, 5, 1, 0, 0, 1, 1);
        tests += 4;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL 5o1_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h1F) begin
            fails++; $display("FAIL 5o1_data: got %h want 1f", cap_d);
        end
        if (cap_p !== 1'b0) begin
            fails++; $display("FAIL 5o1_perr: got %b want 0", cap_p);
        end
        if (cap_f !== 1'b0) begin
            fails++; $display("FAIL 5o1_ferr: got %b want 0", cap_f);
        end
    endtask

    task automatic test_abort;
        int v0;
        v0 = vcount;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64);
        for (int i = 0; i < 3; i++) drive(1'b1, 64);
        drive(1'b0, 32);
        en = 1'b0;
        drive(1'b1, 600);
        en = 1'b1;
        drive(1'b1, 100);
        tests += 2;
        if (vcount !== v0) begin
            fails++; $display("FAIL abort_cnt: got %0d want %0d", vcount, v0);
        end
        if (data !== 8'h1F) begin
            fails++; $display("FAIL abort_hold: got %h want 1f", data);
        end
        drive(1'b0, 64);
        drive(1'b1, 100);
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (data !== 8'h00) begin
            fails++; $display("FAIL midrst_data: got %h want 00", data);
        end
        if (dv !== 1'b0) begin
            fails++; $display("FAIL midrst_valid: got %b want 0", dv);
        end
        if (vcount !== v0) begin
            fails++; $display("FAIL midrst_cnt: got %0d want %0d", vcount, v0);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'h81, 8, 0, 0, 0, 1, 1);
        tests += 3;
        if (vcount !== v0 + 1) begin
            fails++; $display("FAIL post_rst_cnt: got %0d want %0d", vcount, v0 + 1);
        end
        if (cap_d !== 8'h81) begin
            fails++; $display("FAIL post_rst_data: got %h want 81", cap_d);
        end
        if (cap_f !== 1'b0) begin
            fails++; $display("FAIL post_rst_ferr: got %b want 0", cap_f);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_8n2_frame_err();
        test_glitch();
        test_5o1();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
